// File: rtl/unified_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter_pkg
// Shared constants and types for the unified instruction/data memory arbiter.
//   arb_state_e      : owner of the response due in the current cycle
//   F3_*             : load/store width/sign codes (IR funct3 encodings)
//   dm_misaligned()  : data-side alignment check from funct3 and addr[1:0]
// -----------------------------------------------------------------------------
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_RSP_IF = 2'b01,
        ARB_RSP_DM = 2'b10
    } arb_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Only the size field (funct3[1:0]) matters; signedness never affects
    // alignment, so LBU/LHU share the rules of LB/LH.
    function automatic logic dm_misaligned(input logic [2:0] func3,
                                           input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (func3[1:0])
            F3_H[1:0]: mis = addr_lo[0];
            F3_W[1:0]: mis = (addr_lo != 2'b00);
            default:   mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// arb_starve_counter
// Saturating up-counter tracking how many consecutive cycles the fetch port
// has been passed over in favour of the data port.
//   clk, reset : clock, synchronous active-high reset
//   inc        : data granted while fetch was eligible
//   clr        : fetch granted or fetch not eligible (takes priority over inc)
//   cnt        : current count, saturates at LIMIT
//   at_limit   : cnt == LIMIT, fetch must win the next contention
// -----------------------------------------------------------------------------
module arb_starve_counter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int LIMIT = 4,
    parameter int CW    = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          at_limit
);

    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LIMIT_C)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt      = cnt_q;
    assign at_limit = (cnt_q == LIMIT_C);

endmodule

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
// Shares one single-ported unified memory between the instruction fetch port
// and the load/store data port. Data normally wins; a starvation counter
// forces a fetch grant after STARVE_LIMIT consecutive losses. Every grant,
// aligned or not, produces exactly one response in the following cycle.
//
// State table (state_q = owner of the response due this cycle):
//   ARB_IDLE   | no response due
//   ARB_RSP_IF | fetch response due (if_rvalid)
//   ARB_RSP_DM | data response due (dm_rvalid)
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   halt                  : blocks new fetch grants
//   if_req/if_addr        : fetch request       -> if_gnt
//   if_rvalid/rdata/err   : fetch response, one cycle after if_gnt
//   dm_req/we/func3/addr/wdata : data request   -> dm_gnt
//   dm_rvalid/rdata/err   : data response, one cycle after dm_gnt
//   mem_en/we/func3/addr/wdata : memory command (aligned grants only)
//   mem_rdata             : memory read data, one cycle after read mem_en
//   busy                  : a response is due this cycle
// -----------------------------------------------------------------------------
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          halt,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [31:0]   if_rdata,
    output logic          if_err,

    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [2:0]    dm_func3,
    input  logic [AW-1:0] dm_addr,
    input  logic [31:0]   dm_wdata,
    output logic          dm_gnt,
    output logic          dm_rvalid,
    output logic [31:0]   dm_rdata,
    output logic          dm_err,

    output logic          mem_en,
    output logic          mem_we,
    output logic [2:0]    mem_func3,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,

    output logic          busy
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    arb_state_e     state_d;
    arb_state_e     state_q;
    logic           err_d;
    logic           err_q;
    // Response carries memory read data (aligned load or aligned fetch).
    logic           rd_ok_d;
    logic           rd_ok_q;

    logic           if_ok;
    logic           grant_if;
    logic           grant_dm;
    logic           if_mis;
    logic           dm_mis;
    logic           starve_inc;
    logic           starve_clr;
    logic           starve_at_limit;
    logic [SCW-1:0] starve_cnt;

    // -------------------------------------------------------------------------
    // Grant decision
    // -------------------------------------------------------------------------
    assign if_ok = if_req & ~halt;

    always_comb begin
        grant_dm = 1'b0;
        grant_if = 1'b0;
        if (!reset) begin
            if (dm_req && (!starve_at_limit || !if_ok)) begin
                grant_dm = 1'b1;
            end else if (if_ok) begin
                grant_if = 1'b1;
            end
        end
    end

    assign if_gnt = grant_if;
    assign dm_gnt = grant_dm;

    // -------------------------------------------------------------------------
    // Starvation tracking
    // -------------------------------------------------------------------------
    assign starve_inc = grant_dm & if_ok;
    assign starve_clr = grant_if | ~if_ok;

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CW    (SCW)
    ) u_starve (
        .clk      (clk),
        .reset    (reset),
        .inc      (starve_inc),
        .clr      (starve_clr),
        .cnt      (starve_cnt),
        .at_limit (starve_at_limit)
    );

    // -------------------------------------------------------------------------
    // Alignment and memory forwarding
    // -------------------------------------------------------------------------
    assign if_mis = (if_addr[1:0] != 2'b00);
    assign dm_mis = dm_misaligned(dm_func3, dm_addr[1:0]);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_func3 = 3'b000;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (grant_dm && !dm_mis) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_func3 = dm_func3;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (grant_if && !if_mis) begin
            mem_en    = 1'b1;
            mem_func3 = F3_W;
            mem_addr  = if_addr;
        end
    end

    // -------------------------------------------------------------------------
    // Response FSM
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = ARB_IDLE;
        err_d   = 1'b0;
        rd_ok_d = 1'b0;
        if (grant_dm) begin
            state_d = ARB_RSP_DM;
            err_d   = dm_mis;
            rd_ok_d = ~dm_mis & ~dm_we;
        end else if (grant_if) begin
            state_d = ARB_RSP_IF;
            err_d   = if_mis;
            rd_ok_d = ~if_mis;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            rd_ok_q <= rd_ok_d;
        end
    end

    // Responses are masked during reset so a response in flight when reset
    // arrives is dropped in that same cycle rather than leaking out.
    assign if_rvalid = ~reset & (state_q == ARB_RSP_IF);
    assign dm_rvalid = ~reset & (state_q == ARB_RSP_DM);
    assign busy      = ~reset & (state_q != ARB_IDLE);

    assign if_err    = if_rvalid & err_q;
    assign dm_err    = dm_rvalid & err_q;
    assign if_rdata  = (if_rvalid && rd_ok_q) ? mem_rdata : 32'h0;
    assign dm_rdata  = (dm_rvalid && rd_ok_q) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
    import unified_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid, if_err;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [2:0]  dm_func3;
    logic [31:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid, dm_err;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [2:0]  mem_func3;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.STARVE_LIMIT(4), .AW(32)) dut (
        .clk(clk), .reset(reset), .halt(halt),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_func3(dm_func3),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_func3(mem_func3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    // Word-wide single-port memory, read data one cycle after mem_en.
    logic [31:0] mem [0:63];
    always @(posedge clk) begin
        if (reset) begin
            mem[4] <= 32'h0050_0093;
        end else if (mem_en && mem_we) begin
            mem[mem_addr[7:2]] <= mem_wdata;
        end else if (mem_en) begin
            mem_rdata <= mem[mem_addr[7:2]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; halt = 1'b0;
        if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_func3 = 3'b010; dm_addr = '0; dm_wdata = '0;

        // Reset: no grants, no memory access, outputs quiet.
        @(negedge clk); @(negedge clk);
        dm_req = 1'b1; if_req = 1'b1;
        #1;
        chk("rst_dm_gnt", 32'(dm_gnt), 0);
        chk("rst_if_gnt", 32'(if_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_busy",   32'(busy), 0);
        @(negedge clk);
        reset = 1'b0; dm_req = 1'b0; if_req = 1'b0;
        #1;
        chk("post_rst_rvalid", {30'd0, if_rvalid, dm_rvalid}, 0);
        chk("post_rst_err",    {30'd0, if_err, dm_err}, 0);
        chk("post_rst_state",  32'(dut.state_q), 32'(ARB_IDLE));

        // Single fetch.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        #1;
        chk("f_gnt",   32'(if_gnt), 1);
        chk("f_mem",   {mem_en, mem_we, mem_func3}, {1'b1, 1'b0, 3'b010});
        chk("f_addr",  mem_addr, 32'h10);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        chk("f_rvalid", 32'(if_rvalid), 1);
        chk("f_rdata",  if_rdata, 32'h0050_0093);
        chk("f_err",    32'(if_err), 0);
        chk("f_busy",   32'(busy), 1);

        // Store then load.
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_func3 = 3'b010; dm_wdata = 32'hDEAD_BEEF;
        #1;
        chk("st_gnt",   32'(dm_gnt), 1);
        chk("st_mem",   {mem_en, mem_we}, 2'b11);
        chk("st_wdata", mem_wdata, 32'hDEAD_BEEF);
        @(negedge clk);
        dm_we = 1'b0; dm_wdata = '0;
        #1;
        chk("st_rvalid", 32'(dm_rvalid), 1);
        chk("st_rdata",  dm_rdata, 0);
        chk("ld_gnt_b2b", 32'(dm_gnt), 1);
        chk("ld_mem_we", {mem_en, mem_we}, 2'b10);
        @(negedge clk);
        dm_req = 1'b0;
        #1;
        chk("ld_rvalid", 32'(dm_rvalid), 1);
        chk("ld_rdata",  dm_rdata, 32'hDEAD_BEEF);

        // Misaligned word load.
        @(negedge clk);
        dm_req = 1'b1; dm_addr = 32'h22; dm_func3 = 3'b010;
        #1;
        chk("mw_gnt",    32'(dm_gnt), 1);
        chk("mw_mem_en", 32'(mem_en), 0);
        chk("mw_maddr",  mem_addr, 0);
        // Misaligned halfword, back to back.
        @(negedge clk);
        dm_addr = 32'h21; dm_func3 = 3'b001;
        #1;
        chk("mw_rsp", {29'd0, dm_rvalid, dm_err, |dm_rdata}, 3'b110);
        chk("mh_mem_en", 32'(mem_en), 0);
        // Byte load at odd address is aligned.
        @(negedge clk);
        dm_addr = 32'h23; dm_func3 = 3'b100;
        #1;
        chk("mh_err",   {30'd0, dm_rvalid, dm_err}, 2'b11);
        chk("bu_mem",   {mem_en, mem_func3}, {1'b1, 3'b100});
        @(negedge clk);
        dm_req = 1'b0;
        #1;
        chk("bu_err",   {30'd0, dm_rvalid, dm_err}, 2'b10);
        chk("bu_rdata", dm_rdata, 32'hDEAD_BEEF);

        // Misaligned fetch.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h6;
        #1;
        chk("mf_gnt",    {if_gnt, mem_en}, 2'b10);
        @(negedge clk);
        if_req = 1'b0;
        #1;
        chk("mf_rsp", {29'd0, if_rvalid, if_err, |if_rdata}, 3'b110);

        // Contention: data wins 4 times, then fetch once, then data again.
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 0) begin
                dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20; dm_func3 = 3'b010;
                if_req = 1'b1; if_addr = 32'h10;
            end
            #1;
            chk($sformatf("ct_gnt_c%0d", c), {30'd0, if_gnt, dm_gnt},
                (c == 4) ? 32'b10 : 32'b01);
            if (c == 4) chk("ct_starve_lim", 32'(dut.starve_cnt), 4);
            if (c == 5) begin
                chk("ct_starve_clr", 32'(dut.starve_cnt), 0);
                chk("ct_if_rsp", {30'd0, if_rvalid, dm_rvalid}, 2'b10);
                chk("ct_if_rdata", if_rdata, 32'h0050_0093);
            end else if (c > 0) begin
                chk($sformatf("ct_rsp_c%0d", c), {30'd0, if_rvalid, dm_rvalid}, 2'b01);
            end
        end
        @(negedge clk);
        dm_req = 1'b0; if_req = 1'b0;
        #1;
        chk("ct_last_rsp", {30'd0, if_rvalid, dm_rvalid}, 2'b01);
        chk("ct_last_rdata", dm_rdata, 32'hDEAD_BEEF);

        // Halt blocks fetch for 10 cycles; release grants in the same cycle.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 0) begin
                halt = 1'b1; if_req = 1'b1; if_addr = 32'h10;
            end
            #1;
            chk($sformatf("h_no_gnt_c%0d", c), 32'(if_gnt), 0);
            chk($sformatf("h_starve_c%0d", c), 32'(dut.starve_cnt), 0);
        end
        @(negedge clk);
        halt = 1'b0;
        #1;
        chk("h_release_gnt", 32'(if_gnt), 1);

        // Reset while the fetch response is in flight.
        @(negedge clk);
        reset = 1'b1; if_req = 1'b0;
        #1;
        chk("rm_rvalid_c1", 32'(if_rvalid), 0);
        chk("rm_busy_c1",   32'(busy), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rm_rvalid_c2", 32'(if_rvalid), 0);
        chk("rm_state",     32'(dut.state_q), 32'(ARB_IDLE));
        chk("rm_starve",    32'(dut.starve_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
